// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, totals and RGB222 colour types
package vga_timing_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam bit VGA_SYNC_ACTIVE = 1'b0;
  localparam int VGA_FB_LATENCY = 1;
  typedef logic [5:0] rgb222_t;
  localparam rgb222_t RGB_FG = 6'b111111;
  localparam rgb222_t RGB_BG = 6'b000000;
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: W-bit, D-deep shift register with clock enable and sync clear
module vga_delay_line #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         ce_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  if (D == 0) begin : g_wire
    assign q_o = d_i;
  end else begin : g_reg
    logic [W-1:0] sr_q [D];
    always_ff @(posedge clk)
      if (clr_i) sr_q <= '{default: '0};
      else if (ce_i) begin
        sr_q[0] <= d_i;
        for (int i = 1; i < D; i++) sr_q[i] <= sr_q[i-1];
      end
    assign q_o = sr_q[D-1];
  end
endmodule

// File: rtl/vga_timing_controller.sv
// vga_timing_controller: VGA raster counters, sync/blank alignment and RGB222 pixel output
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int      H_ACTIVE    = VGA_H_ACTIVE,
  parameter int      H_FP        = VGA_H_FP,
  parameter int      H_SYNC      = VGA_H_SYNC,
  parameter int      H_BP        = VGA_H_BP,
  parameter int      V_ACTIVE    = VGA_V_ACTIVE,
  parameter int      V_FP        = VGA_V_FP,
  parameter int      V_SYNC      = VGA_V_SYNC,
  parameter int      V_BP        = VGA_V_BP,
  parameter bit      SYNC_ACTIVE = VGA_SYNC_ACTIVE,
  parameter int      FB_LATENCY  = VGA_FB_LATENCY,
  parameter rgb222_t FG_COLOUR   = RGB_FG,
  parameter rgb222_t BG_COLOUR   = RGB_BG
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_ce,
  input  logic       colour,
  output logic [9:0] counter_H,
  output logic [9:0] counter_V,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic       h_sync,
  output logic       v_sync,
  output logic [5:0] rgb_out
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic [9:0] h_q, h_d, v_q, v_d;
  logic hs_raw, vs_raw, de;
  logic hs_dl, vs_dl, de_dl;
  logic hs_q, hs_d, vs_q, vs_d;
  rgb222_t rgb_q, rgb_d;
  assign de = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_raw = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_raw = (v_q >= VS_BEG) && (v_q < VS_END);
  always_comb begin
    h_d = (h_q == H_LAST) ? '0 : h_q + 10'd1;
    v_d = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + 10'd1;
    hs_d = hs_dl ? SYNC_ACTIVE : !SYNC_ACTIVE;
    vs_d = vs_dl ? SYNC_ACTIVE : !SYNC_ACTIVE;
    rgb_d = !de_dl ? '0 : colour ? FG_COLOUR : BG_COLOUR;
  end
  vga_delay_line #(.W(3), .D(FB_LATENCY)) u_align (
    .clk  (clk),
    .clr_i(reset),
    .ce_i (pixel_ce),
    .d_i  ({hs_raw, vs_raw, de}),
    .q_o  ({hs_dl, vs_dl, de_dl})
  );
  always_ff @(posedge clk)
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
      hs_q <= !SYNC_ACTIVE;
      vs_q <= !SYNC_ACTIVE;
      rgb_q <= '0;
    end else if (pixel_ce) begin
      h_q <= h_d;
      v_q <= v_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      rgb_q <= rgb_d;
    end
  assign counter_H = h_q;
  assign counter_V = v_q;
  assign display_on = de;
  assign line_start = (h_q == '0);
  assign frame_start = (h_q == '0) && (v_q == '0);
  assign h_sync = hs_q;
  assign v_sync = vs_q;
  assign rgb_out = rgb_q;
endmodule

// File: tb/tb_vga_timing_controller.sv
// tb_vga_timing_controller: randomized scoreboard check of two controller instances against a raster model
module tb_vga_timing_controller;
  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, lat;
    bit sa;
  } tim_t;
  typedef struct {
    int h, v, rgb;
    bit de, ls, fs, hsy, vsy;
  } exp_t;
  logic clk = 1'b0;
  logic reset, pixel_ce, colour;
  logic [9:0] ch_a, cv_a, ch_b, cv_b;
  logic de_a, ls_a, fs_a, hs_a, vs_a, de_b, ls_b, fs_b, hs_b, vs_b;
  logic [5:0] rgb_a, rgb_b;
  tim_t tm[2];
  int n[2];
  int hist[2][$];
  bit ph[2], pv[2];
  int prgb[2];
  exp_t exp_q[2][$];
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  vga_timing_controller dut_a (
    .clk(clk), .reset(reset), .pixel_ce(pixel_ce), .colour(colour),
    .counter_H(ch_a), .counter_V(cv_a), .display_on(de_a), .line_start(ls_a),
    .frame_start(fs_a), .h_sync(hs_a), .v_sync(vs_a), .rgb_out(rgb_a)
  );
  vga_timing_controller #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_ACTIVE(1'b1), .FB_LATENCY(2)
  ) dut_b (
    .clk(clk), .reset(reset), .pixel_ce(pixel_ce), .colour(colour),
    .counter_H(ch_b), .counter_V(cv_b), .display_on(de_b), .line_start(ls_b),
    .frame_start(fs_b), .h_sync(hs_b), .v_sync(vs_b), .rgb_out(rgb_b)
  );
  function automatic tim_t mk(int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb, int lat, bit sa);
    tim_t t;
    t.ha = ha; t.hf = hf; t.hs = hs; t.hb = hb;
    t.va = va; t.vf = vf; t.vs = vs; t.vb = vb;
    t.lat = lat; t.sa = sa;
    return t;
  endfunction
  // pipeline position p is -1 when the stage holds cleared (blank, sync idle) contents
  task automatic model_step(input int i, input bit r, input bit c, input bit col);
    tim_t t;
    int ht, vt, p, x, y;
    exp_t e;
    t = tm[i];
    ht = t.ha + t.hf + t.hs + t.hb;
    vt = t.va + t.vf + t.vs + t.vb;
    if (r) begin
      n[i] = 0;
      hist[i].delete();
      repeat (t.lat) hist[i].push_back(-1);
      ph[i] = !t.sa;
      pv[i] = !t.sa;
      prgb[i] = 0;
    end else if (c) begin
      hist[i].push_back(n[i]);
      p = hist[i].pop_front();
      if (p < 0) begin
        ph[i] = !t.sa;
        pv[i] = !t.sa;
        prgb[i] = 0;
      end else begin
        x = p % ht;
        y = p / ht;
        ph[i] = (x >= t.ha + t.hf && x < t.ha + t.hf + t.hs) ? t.sa : !t.sa;
        pv[i] = (y >= t.va + t.vf && y < t.va + t.vf + t.vs) ? t.sa : !t.sa;
        prgb[i] = (x < t.ha && y < t.va && col) ? 63 : 0;
      end
      n[i] = (n[i] + 1) % (ht * vt);
    end
    e.h = n[i] % ht;
    e.v = n[i] / ht;
    e.de = (e.h < t.ha) && (e.v < t.va);
    e.ls = (e.h == 0);
    e.fs = (n[i] == 0);
    e.hsy = ph[i];
    e.vsy = pv[i];
    e.rgb = prgb[i];
    exp_q[i].push_back(e);
  endtask
  task automatic check(input string name, input int i, input int act, input int want);
    checks++;
    if (act != want) begin
      fails++;
      if (fails <= 30) $display("FAIL %s dut%0d @%0t: got %0d expected %0d", name, i, $time, act, want);
    end
  endtask
  task automatic cyc(input bit r, input bit c, input bit col);
    reset = r;
    pixel_ce = c;
    colour = col;
    model_step(0, r, c, col);
    model_step(1, r, c, col);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++)
      if (exp_q[i].size() > 0) begin
        e = exp_q[i].pop_front();
        check("counter_H", i, int'(i == 0 ? ch_a : ch_b), e.h);
        check("counter_V", i, int'(i == 0 ? cv_a : cv_b), e.v);
        check("display_on", i, int'(i == 0 ? de_a : de_b), int'(e.de));
        check("line_start", i, int'(i == 0 ? ls_a : ls_b), int'(e.ls));
        check("frame_start", i, int'(i == 0 ? fs_a : fs_b), int'(e.fs));
        check("h_sync", i, int'(i == 0 ? hs_a : hs_b), int'(e.hsy));
        check("v_sync", i, int'(i == 0 ? vs_a : vs_b), int'(e.vsy));
        check("rgb_out", i, int'(i == 0 ? rgb_a : rgb_b), e.rgb);
      end
  end
  initial begin
    tm[0] = mk(640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0);
    tm[1] = mk(20, 3, 5, 4, 10, 2, 2, 3, 2, 1'b1);
    repeat (3) cyc(1'b1, 1'b1, 1'($urandom_range(1)));
    repeat (2000) cyc(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 2000; k++) cyc(1'b0, 1'(k % 2 == 0), 1'($urandom_range(1)));
    while (!(cv_b == 10'd5 && ch_b == 10'd7)) cyc(1'b0, 1'b1, 1'($urandom_range(1)));
    cyc(1'b1, 1'b1, 1'b1);
    repeat (1200) cyc(1'b0, 1'b1, 1'b1);
    repeat (50000) cyc($urandom_range(2999) == 0, $urandom_range(3) != 0, 1'($urandom_range(1)));
    reset = 1'b0;
    pixel_ce = 1'b0;
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) check("queue_drained", i, exp_q[i].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
